// File: rtl/led_sequencer.sv
// led_sequencer: parametrised LED pattern generator.
// A prescaler produces one step every DIVIDE enabled clocks. Each step
// advances a spin, bounce, blink or hold pattern over NUM_LEDS outputs.
// TICK and CYCLE are registered strobes for the step and the pattern-cycle
// boundary. TST brings out one prescaler bit for a scope.
module led_sequencer #(
  parameter int NUM_LEDS = 4,
  parameter int DIVIDE   = 25000000,
  parameter int TEST_TAP = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic                DIR,
  output logic [NUM_LEDS-1:0] LEDS,
  output logic                TICK,
  output logic                CYCLE,
  output logic                TST
);

  localparam int CNT_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  // Position the bounce turns back to from the top end; unused when NUM_LEDS == 1.
  localparam logic [POS_W-1:0] POS_PREV = (NUM_LEDS > 1) ? POS_W'(NUM_LEDS - 2) : POS_W'(0);

  typedef enum logic [1:0] {
    MODE_SPIN   = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  localparam logic BDIR_UP   = 1'b0;
  localparam logic BDIR_DOWN = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             bdir_q, bdir_d;
  logic             phase_q, phase_d;
  mode_e            mode_q;
  logic             tick_q, cycle_q;
  logic             step_s, wrap_s;
  mode_e            mode_in_s;
  logic [NUM_LEDS-1:0] leds_s;

  assign mode_in_s = mode_e'(MODE);

  // Prescaler next value and the step strobe it generates.
  always_comb begin
    cnt_d  = cnt_q;
    step_s = EN && (cnt_q == CNT_LAST);
    if (EN) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pattern next state and cycle-boundary detection, chosen by the incoming MODE.
  always_comb begin
    pos_d   = pos_q;
    bdir_d  = bdir_q;
    phase_d = phase_q;
    wrap_s  = 1'b0;
    case (mode_in_s)
      MODE_SPIN: begin
        if (!DIR) begin
          if (pos_q == POS_LAST) begin
            pos_d  = '0;
            wrap_s = 1'b1;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else begin
          if (pos_q == '0) begin
            pos_d  = POS_LAST;
            wrap_s = 1'b1;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      MODE_BOUNCE: begin
        if (NUM_LEDS == 1) begin
          // Single LED: nowhere to move, every step closes a cycle.
          wrap_s = 1'b1;
        end else if (bdir_q == BDIR_UP) begin
          if (pos_q == POS_LAST) begin
            bdir_d = BDIR_DOWN;
            pos_d  = POS_PREV;
            wrap_s = (POS_PREV == '0);
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else begin
          if (pos_q == '0) begin
            bdir_d = BDIR_UP;
            pos_d  = POS_W'(1);
          end else begin
            // Arriving at index 0 on the way down closes a bounce cycle.
            pos_d  = pos_q - POS_W'(1);
            wrap_s = (pos_q == POS_W'(1));
          end
        end
      end
      MODE_BLINK: begin
        phase_d = ~phase_q;
        wrap_s  = phase_q;
      end
      MODE_HOLD: begin
        wrap_s = 1'b0;
      end
      default: begin
        wrap_s = 1'b0;
      end
    endcase
  end

  // State registers: prescaler always, pattern state only on a step.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      pos_q   <= '0;
      bdir_q  <= BDIR_UP;
      phase_q <= 1'b0;
      mode_q  <= MODE_SPIN;
      tick_q  <= 1'b0;
      cycle_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= step_s;
      cycle_q <= step_s & wrap_s;
      if (step_s) begin
        mode_q  <= mode_in_s;
        pos_q   <= pos_d;
        bdir_q  <= bdir_d;
        phase_q <= phase_d;
      end else begin
        mode_q  <= mode_q;
        pos_q   <= pos_q;
        bdir_q  <= bdir_q;
        phase_q <= phase_q;
      end
    end
  end

  // LED decode purely from registers so inputs can never glitch the pins.
  always_comb begin
    leds_s = '0;
    if (mode_q == MODE_BLINK) begin
      leds_s = {NUM_LEDS{phase_q}};
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        leds_s[i] = (pos_q == POS_W'(i));
      end
    end
  end

  assign LEDS  = leds_s;
  assign TICK  = tick_q;
  assign CYCLE = cycle_q;
  assign TST   = cnt_q[TEST_TAP];

endmodule
